// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate-left, rotate-right, ping-pong or binary count,
// advanced by a programmable prescaler or a manual step pulse.
module led_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic             step,
    output logic [WIDTH-1:0] ledout,
    output logic             tick,
    output logic             dir
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt, eff_m1;
    logic [1:0]       mode_q;
    logic             init;
    logic             adv_auto, adv;
    logic [WIDTH-1:0] led_nxt;
    logic             dir_nxt;

    function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
        case (m)
            2'd0:    seed = ONE;
            2'd1:    seed = MSB;
            2'd2:    seed = ONE;
            default: seed = '0;
        endcase
    endfunction

    always_comb begin
        eff_m1   = (period == '0) ? '0 : period - CNT_W'(1);
        // >= rather than == so a shrinking period takes effect immediately
        adv_auto = en && (cnt >= eff_m1);
        adv      = adv_auto | step;

        cnt_nxt = cnt;
        if (en)
            cnt_nxt = adv_auto ? '0 : cnt + CNT_W'(1);
        if (step)
            cnt_nxt = '0;

        led_nxt = ledout;
        dir_nxt = dir;
        if (mode_q != 2'd3 && ledout == '0) begin
            led_nxt = seed(mode_q);
            dir_nxt = 1'b0;
        end else begin
            case (mode_q)
                2'd0: led_nxt = {ledout[WIDTH-2:0], ledout[WIDTH-1]};
                2'd1: led_nxt = {ledout[0], ledout[WIDTH-1:1]};
                2'd2: begin
                    // Turn around on the end LED itself so it is shown only once
                    if (!dir) begin
                        led_nxt = ledout << 1;
                        if (led_nxt == MSB) dir_nxt = 1'b1;
                    end else begin
                        led_nxt = ledout >> 1;
                        if (led_nxt == ONE) dir_nxt = 1'b0;
                    end
                end
                default: led_nxt = ledout + ONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledout <= '0;
            cnt    <= '0;
            tick   <= 1'b0;
            dir    <= 1'b0;
            init   <= 1'b0;
            mode_q <= 2'd0;
        end else if (!init || mode != mode_q) begin
            ledout <= seed(mode);
            cnt    <= '0;
            tick   <= 1'b0;
            dir    <= 1'b0;
            init   <= 1'b1;
            mode_q <= mode;
        end else begin
            cnt  <= cnt_nxt;
            tick <= adv;
            if (adv) begin
                ledout <= led_nxt;
                dir    <= dir_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed checks of led_pattern_gen at WIDTH=8 and WIDTH=4.
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, step, en4, step4;
    logic [1:0]  mode, mode4;
    logic [29:0] period, period4;
    logic [7:0]  led8;
    logic [3:0]  led4;
    logic        tick8, dir8, tick4, dir4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(8), .CNT_W(30)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .step(step), .ledout(led8), .tick(tick8), .dir(dir8)
    );

    led_pattern_gen #(.WIDTH(4), .CNT_W(30)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .period(period4),
        .step(step4), .ledout(led4), .tick(tick4), .dir(dir4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_led;
    logic [8:0] pp [0:14];

    initial begin
        // {dir, ledout} after each ping-pong step starting from 0x01
        pp = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h180, 9'h140,
               9'h120, 9'h110, 9'h108, 9'h104, 9'h102, 9'h001, 9'h002};

        rst_n = 1'b0; en = 1'b1; step = 1'b0; mode = 2'd0; period = 30'd3;
        en4 = 1'b0; step4 = 1'b0; mode4 = 2'd3; period4 = 30'd0;

        edge_clk();
        chk("rst_led",  led8,  0);
        chk("rst_tick", tick8, 0);
        chk("rst_dir",  dir8,  0);
        rst_n = 1'b1;

        // Rotate left, period 3
        edge_clk();
        chk("init_led",  led8,  8'h01);
        chk("init_tick", tick8, 0);
        chk("init_led4", led4,  4'h0);
        exp_led = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            edge_clk();
            if (i % 3 == 0) exp_led = {exp_led[6:0], exp_led[7]};
            chk("rotl_led",  led8,  exp_led);
            chk("rotl_tick", tick8, (i % 3 == 0));
        end

        // Ping-pong, period 1
        mode = 2'd2; period = 30'd1;
        edge_clk();
        chk("pp_seed",      led8,  8'h01);
        chk("pp_seed_tick", tick8, 0);
        chk("pp_seed_dir",  dir8,  0);
        for (int i = 0; i < 15; i++) begin
            edge_clk();
            chk("pp_led",  led8,  pp[i][7:0]);
            chk("pp_dir",  dir8,  pp[i][8]);
            chk("pp_tick", tick8, 1);
        end

        // Binary count, period 0 acts as 1
        en4 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            edge_clk();
            chk("cnt_led4",  led4,  i % 16);
            chk("cnt_tick4", tick4, 1);
        end
        en4 = 1'b0;

        // Pause and manual step
        mode = 2'd0; period = 30'd3; en = 1'b0;
        edge_clk();
        chk("pause_seed", led8, 8'h01);
        step = 1'b1;
        edge_clk();
        chk("step1_led", led8, 8'h02);
        chk("step1_tick", tick8, 1);
        edge_clk();
        chk("step2_led", led8, 8'h04);
        step = 1'b0;
        for (int i = 0; i < 100; i++) begin
            edge_clk();
            chk("frozen_led",  led8,  8'h04);
            chk("frozen_tick", tick8, 0);
        end
        step = 1'b1;
        edge_clk();
        chk("step3_led",  led8,  8'h08);
        chk("step3_tick", tick8, 1);
        step = 1'b0;
        edge_clk();
        chk("post_step_led",  led8,  8'h08);
        chk("post_step_tick", tick8, 0);

        // Resume: first auto advance three edges later
        en = 1'b1;
        edge_clk();
        chk("resume_t1", tick8, 0);
        edge_clk();
        chk("resume_t2", tick8, 0);
        edge_clk();
        chk("resume_led",  led8,  8'h10);
        chk("resume_tick", tick8, 1);
        edge_clk();
        chk("run_tick", tick8, 0);

        // Mode change wins over step in the same cycle
        mode = 2'd1; step = 1'b1;
        edge_clk();
        chk("mchg_led",  led8,  8'h80);
        chk("mchg_tick", tick8, 0);
        chk("mchg_dir",  dir8,  0);
        step = 1'b0;
        edge_clk();
        chk("mchg_cnt1", tick8, 0);
        edge_clk();
        chk("mchg_cnt2", tick8, 0);
        edge_clk();
        chk("rotr_led",  led8,  8'h40);
        chk("rotr_tick", tick8, 1);

        // Step coinciding with terminal count gives one advance
        edge_clk();
        edge_clk();
        step = 1'b1;
        edge_clk();
        chk("dual_led",  led8,  8'h20);
        chk("dual_tick", tick8, 1);
        step = 1'b0;
        edge_clk();
        chk("dual_after", led8, 8'h20);

        // Async reset mid-run while dir = 1
        mode = 2'd2; period = 30'd1;
        edge_clk();
        chk("pp2_seed", led8, 8'h01);
        repeat (7) edge_clk();
        chk("pp2_led", led8, 8'h80);
        chk("pp2_dir", dir8, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_led",  led8,  0);
        chk("arst_tick", tick8, 0);
        chk("arst_dir",  dir8,  0);
        #2;
        rst_n = 1'b1;
        edge_clk();
        chk("reinit_led",  led8,  8'h01);
        chk("reinit_tick", tick8, 0);
        chk("reinit_dir",  dir8,  0);
        edge_clk();
        chk("reinit_adv",  led8,  8'h02);
        chk("reinit_tick2", tick8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
